// File: rtl/eth_echo_pkg.sv
// Shared definitions for the Ethernet echo responder: FSM encoding, header geometry
// and a helper that picks one byte out of a 48-bit MAC (byte 0 = bits [47:40]).
package eth_echo_pkg;

  localparam int ETH_MAC_LEN = 6;
  localparam int ETH_HDR_LEN = 14;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam logic [1:0] S_RECV = 2'd0;
  localparam logic [1:0] S_DROP = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
    logic [47:0] sh;
    sh = mac << (8 * k);
    return sh[47:40];
  endfunction

endpackage

// File: rtl/eth_echo_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port with
// read enable so the read data holds while the output pipeline is stalled.
module eth_echo_frame_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_axis_echo_responder.sv
// Store-and-forward echo endpoint: buffers frames for this station (or broadcast) and
// replays them with dst = original src and src = LOCAL_MAC.
module eth_axis_echo_responder
  import eth_echo_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter int          BUF_DEPTH = 2048,
  parameter bit          PROMISC   = 1'b0
) (
  input  logic        clock125,
  input  logic        reset,
  input  logic        cfg_enable,
  input  logic [7:0]  rx_axis_tdata,
  input  logic        rx_axis_tkeep,
  input  logic        rx_axis_tvalid,
  output logic        rx_axis_tready,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tkeep,
  output logic        tx_axis_tvalid,
  input  logic        tx_axis_tready,
  output logic        tx_axis_tlast,
  output logic        tx_axis_tuser,
  output logic [15:0] echo_count,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = $clog2(BUF_DEPTH + 1);

  logic [1:0]    state_reg;
  logic          rdy_reg;
  logic [LW-1:0] wr_idx_reg, len_reg, rd_idx_reg;
  logic [47:0]   src_mac_reg;
  logic          uc_ok_reg, bc_ok_reg;
  logic          s1_valid_reg, s1_hdr_reg, s1_last_reg;
  logic [7:0]    s1_hdr_data_reg;
  logic          tx_valid_reg, tx_last_reg;
  logic [7:0]    tx_data_reg;
  logic [15:0]   echo_cnt_reg, drop_cnt_reg;

  logic          rx_fire, tx_fire, advance, issue, keep_frame;
  logic          uc_ok, bc_ok, hdr_bad, frame_ok, overflow;
  logic [7:0]    issue_hdr_data, ram_rd_data, s1_data;
  logic [2:0]    loc_k;
  logic          unused_ok;

  assign unused_ok = rx_axis_tkeep;

  assign rx_axis_tready = rdy_reg & (state_reg != S_SEND);
  assign rx_fire        = rx_axis_tvalid & rx_axis_tready;
  assign tx_fire        = tx_valid_reg & tx_axis_tready;

  // Destination filter runs byte by byte; a frame stays alive while either match holds.
  assign uc_ok = ((wr_idx_reg == '0) | uc_ok_reg) &
                 (rx_axis_tdata == mac_byte(LOCAL_MAC, wr_idx_reg[2:0]));
  assign bc_ok = ((wr_idx_reg == '0) | bc_ok_reg) &
                 (rx_axis_tdata == mac_byte(BCAST_MAC, wr_idx_reg[2:0]));
  assign hdr_bad = ((wr_idx_reg < LW'(ETH_MAC_LEN)) & !PROMISC & !(uc_ok | bc_ok)) |
                   ((wr_idx_reg == '0) & !cfg_enable);
  assign frame_ok   = !rx_axis_tuser & (wr_idx_reg >= LW'(ETH_HDR_LEN - 1));
  assign overflow   = (wr_idx_reg == LW'(BUF_DEPTH - 1));
  assign keep_frame = (state_reg == S_RECV) & rx_fire & rx_axis_tlast & !hdr_bad & frame_ok;

  // Two-stage read-ahead: stage 1 holds RAM/header byte, stage 2 is the AXIS register.
  assign advance = !tx_valid_reg | tx_axis_tready;
  assign issue   = (state_reg == S_SEND) & advance & (rd_idx_reg < len_reg);
  assign s1_data = s1_hdr_reg ? s1_hdr_data_reg : ram_rd_data;

  always_comb begin
    loc_k = 3'(rd_idx_reg - LW'(ETH_MAC_LEN));
    if (rd_idx_reg < LW'(ETH_MAC_LEN)) issue_hdr_data = mac_byte(src_mac_reg, rd_idx_reg[2:0]);
    else                               issue_hdr_data = mac_byte(LOCAL_MAC, loc_k);
  end

  eth_echo_frame_ram #(.DEPTH(BUF_DEPTH)) u_ram (
    .clk     (clock125),
    .wr_en   ((state_reg == S_RECV) & rx_fire & (wr_idx_reg >= LW'(2 * ETH_MAC_LEN))),
    .wr_addr (wr_idx_reg[AW-1:0]),
    .wr_data (rx_axis_tdata),
    .rd_en   (issue),
    .rd_addr (rd_idx_reg[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clock125 or posedge reset) begin
    if (reset) begin
      state_reg    <= S_RECV;
      rdy_reg      <= 1'b0;
      wr_idx_reg   <= '0;
      len_reg      <= '0;
      src_mac_reg  <= '0;
      uc_ok_reg    <= 1'b0;
      bc_ok_reg    <= 1'b0;
      echo_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      rdy_reg <= 1'b1;
      case (state_reg)
        S_RECV: if (rx_fire) begin
          wr_idx_reg <= wr_idx_reg + 1'b1;
          uc_ok_reg  <= uc_ok;
          bc_ok_reg  <= bc_ok;
          if (wr_idx_reg >= LW'(ETH_MAC_LEN) && wr_idx_reg < LW'(2 * ETH_MAC_LEN))
            src_mac_reg <= {src_mac_reg[39:0], rx_axis_tdata};
          if (hdr_bad) begin
            if (rx_axis_tlast) begin
              drop_cnt_reg <= drop_cnt_reg + 1'b1;
              wr_idx_reg   <= '0;
            end else begin
              state_reg <= S_DROP;
            end
          end else if (rx_axis_tlast) begin
            if (frame_ok) begin
              len_reg   <= wr_idx_reg + 1'b1;
              state_reg <= S_SEND;
            end else begin
              drop_cnt_reg <= drop_cnt_reg + 1'b1;
              wr_idx_reg   <= '0;
            end
          end else if (overflow) begin
            state_reg <= S_DROP;
          end
        end
        S_DROP: if (rx_fire && rx_axis_tlast) begin
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
          wr_idx_reg   <= '0;
          state_reg    <= S_RECV;
        end
        S_SEND: if (tx_fire && tx_last_reg) begin
          echo_cnt_reg <= echo_cnt_reg + 1'b1;
          wr_idx_reg   <= '0;
          state_reg    <= S_RECV;
        end
        default: state_reg <= S_RECV;
      endcase
    end
  end

  always_ff @(posedge clock125 or posedge reset) begin
    if (reset) begin
      rd_idx_reg      <= '0;
      s1_valid_reg    <= 1'b0;
      s1_hdr_reg      <= 1'b0;
      s1_last_reg     <= 1'b0;
      s1_hdr_data_reg <= '0;
      tx_valid_reg    <= 1'b0;
      tx_data_reg     <= '0;
      tx_last_reg     <= 1'b0;
    end else begin
      // Byte 0 comes from the captured src MAC, so it can be staged on the tlast cycle.
      if (keep_frame) begin
        s1_valid_reg    <= 1'b1;
        s1_hdr_reg      <= 1'b1;
        s1_last_reg     <= 1'b0;
        s1_hdr_data_reg <= mac_byte(src_mac_reg, 3'd0);
        rd_idx_reg      <= LW'(1);
      end else if (advance) begin
        if (issue) begin
          s1_valid_reg    <= 1'b1;
          s1_hdr_reg      <= (rd_idx_reg < LW'(2 * ETH_MAC_LEN));
          s1_last_reg     <= (rd_idx_reg == len_reg - 1'b1);
          s1_hdr_data_reg <= issue_hdr_data;
          rd_idx_reg      <= rd_idx_reg + 1'b1;
        end else begin
          s1_valid_reg <= 1'b0;
        end
      end
      if (advance) begin
        tx_valid_reg <= s1_valid_reg;
        tx_last_reg  <= s1_valid_reg & s1_last_reg;
        if (s1_valid_reg) tx_data_reg <= s1_data;
      end
    end
  end

  assign tx_axis_tdata  = tx_data_reg;
  assign tx_axis_tvalid = tx_valid_reg;
  assign tx_axis_tlast  = tx_last_reg;
  assign tx_axis_tkeep  = 1'b1;
  assign tx_axis_tuser  = 1'b0;
  assign echo_count     = echo_cnt_reg;
  assign drop_count     = drop_cnt_reg;

endmodule

// File: tb/tb_eth_axis_echo_responder.sv
// Directed bench for the echo responder: a filtering instance and a promiscuous one,
// shared stimulus bus, negedge monitor with handshake-stability checks.
module tb_eth_axis_echo_responder;

  localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC   = 48'hAA_BB_CC_DD_EE_FF;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_09;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam int BD = 64;

  logic clock125 = 1'b0;
  logic reset = 1'b1;
  logic cfg_enable = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_last = 1'b0, rx_user = 1'b0;
  logic tx_ready = 1'b1;
  logic rnd_ready = 1'b0;
  logic sel = 1'b0;

  logic [7:0]  d0_tdata, d1_tdata;
  logic        d0_rx_ready, d1_rx_ready, d0_tkeep, d1_tkeep, d0_tvalid, d1_tvalid;
  logic        d0_tlast, d1_tlast, d0_tuser, d1_tuser;
  logic [15:0] d0_echo, d1_echo, d0_drop, d1_drop;

  eth_axis_echo_responder #(.LOCAL_MAC(LMAC), .BUF_DEPTH(BD), .PROMISC(1'b0)) dut (
    .clock125(clock125), .reset(reset), .cfg_enable(cfg_enable),
    .rx_axis_tdata(rx_data), .rx_axis_tkeep(1'b1), .rx_axis_tvalid(rx_valid & !sel),
    .rx_axis_tready(d0_rx_ready), .rx_axis_tlast(rx_last), .rx_axis_tuser(rx_user),
    .tx_axis_tdata(d0_tdata), .tx_axis_tkeep(d0_tkeep), .tx_axis_tvalid(d0_tvalid),
    .tx_axis_tready(tx_ready), .tx_axis_tlast(d0_tlast), .tx_axis_tuser(d0_tuser),
    .echo_count(d0_echo), .drop_count(d0_drop));

  eth_axis_echo_responder #(.LOCAL_MAC(LMAC), .BUF_DEPTH(BD), .PROMISC(1'b1)) dut_p (
    .clock125(clock125), .reset(reset), .cfg_enable(cfg_enable),
    .rx_axis_tdata(rx_data), .rx_axis_tkeep(1'b1), .rx_axis_tvalid(rx_valid & sel),
    .rx_axis_tready(d1_rx_ready), .rx_axis_tlast(rx_last), .rx_axis_tuser(rx_user),
    .tx_axis_tdata(d1_tdata), .tx_axis_tkeep(d1_tkeep), .tx_axis_tvalid(d1_tvalid),
    .tx_axis_tready(tx_ready), .tx_axis_tlast(d1_tlast), .tx_axis_tuser(d1_tuser),
    .echo_count(d1_echo), .drop_count(d1_drop));

  always #4 clock125 = ~clock125;

  int cyc = 0;
  always @(posedge clock125) cyc <= cyc + 1;

  logic       cur_ready, m_valid, m_last;
  logic [7:0] m_data;
  assign cur_ready = sel ? d1_rx_ready : d0_rx_ready;
  assign m_valid   = sel ? d1_tvalid : d0_tvalid;
  assign m_data    = sel ? d1_tdata  : d0_tdata;
  assign m_last    = sel ? d1_tlast  : d0_tlast;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: a byte seen valid&ready at negedge is accepted on the following posedge.
  logic [7:0] got_q[$];
  int   first_cyc = -1;
  logic got_last = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic prev_last = 1'b0;

  initial forever begin
    @(negedge clock125);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_valid", 32'(m_valid), 32'd1);
        check("tx_hold_data", 32'(m_data), 32'(prev_data));
        check("tx_hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (m_valid && tx_ready) begin
        got_q.push_back(m_data);
        if (m_last) got_last = 1'b1;
      end
      prev_stall = m_valid && !tx_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial forever begin
    @(posedge clock125);
    #1;
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [7:0] fbuf [0:127];
  int last_acc_cyc = 0;

  function automatic logic [7:0] mb(input logic [47:0] mac, input int k);
    logic [47:0] t;
    t = mac >> (8 * (5 - k));
    return t[7:0];
  endfunction

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input int len, input int seed);
    for (int i = 0; i < len; i++)
      fbuf[i] = (i < 6) ? mb(dst, i) : (i < 12) ? mb(src, i - 6) : 8'(i * 7 + seed);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_last  = 1'b0;
    first_cyc = -1;
  endtask

  task automatic drive_frame(input int len, input logic user);
    int  w;
    logic ok;
    for (int i = 0; i < len; i++) begin
      rx_data  = fbuf[i];
      rx_valid = 1'b1;
      rx_last  = (i == len - 1);
      rx_user  = user & (i == len - 1);
      w = 0;
      ok = 1'b0;
      while (!ok && w < 200) begin
        @(negedge clock125);
        ok = cur_ready;
        @(posedge clock125);
        #1;
        w++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $error("FAIL rx_accept_timeout: observed=byte %0d not accepted expected=accepted", i);
        break;
      end
      if (i == len - 1) last_acc_cyc = cyc;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_user  = 1'b0;
  endtask

  task automatic wait_echo(input string tag);
    int w = 0;
    while (!got_last && w < 400) begin
      @(posedge clock125);
      #1;
      w++;
    end
    check({tag, "_done"}, 32'(got_last), 32'd1);
  endtask

  task automatic check_echo(input string tag, input int len, input logic [47:0] src);
    logic [7:0] e;
    check({tag, "_len"}, 32'(got_q.size()), 32'(len));
    for (int k = 0; k < len && k < got_q.size(); k++) begin
      e = (k < 6) ? mb(src, k) : (k < 12) ? mb(LMAC, k - 6) : fbuf[k];
      check($sformatf("%s_byte%0d", tag, k), 32'(got_q[k]), 32'(e));
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock125);
      #1;
    end
  endtask

  initial begin
    // Reset state
    idle_cycles(3);
    check("rst_tvalid", 32'(d0_tvalid), 32'd0);
    check("rst_tdata", 32'(d0_tdata), 32'd0);
    check("rst_tlast", 32'(d0_tlast), 32'd0);
    check("rst_rx_ready", 32'(d0_rx_ready), 32'd0);
    check("rst_echo", 32'(d0_echo), 32'd0);
    check("rst_drop", 32'(d0_drop), 32'd0);
    check("tkeep_const", 32'(d0_tkeep), 32'd1);
    check("tuser_const", 32'(d0_tuser), 32'd0);
    reset = 1'b0;
    #1;
    check("rx_ready_first_cycle", 32'(d0_rx_ready), 32'd0);
    idle_cycles(1);
    check("rx_ready_after", 32'(d0_rx_ready), 32'd1);

    // 60-byte unicast frame: header swap, payload intact, first tvalid two cycles after tlast cycle
    clear_mon();
    build(LMAC, SRC, 60, 3);
    drive_frame(60, 1'b0);
    wait_echo("uc60");
    check_echo("uc60", 60, SRC);
    check("uc60_latency", 32'(first_cyc), 32'((last_acc_cyc - 1) + 2));
    check("uc60_echo", 32'(d0_echo), 32'd1);
    check("uc60_drop", 32'(d0_drop), 32'd0);

    // Broadcast, exactly BUF_DEPTH bytes, random back-pressure
    clear_mon();
    rnd_ready = 1'b1;
    build(BCAST, 48'h12_34_56_78_9A_BC, 64, 11);
    drive_frame(64, 1'b0);
    wait_echo("bc64");
    rnd_ready = 1'b0;
    idle_cycles(2);
    check_echo("bc64", 64, 48'h12_34_56_78_9A_BC);
    check("bc64_echo", 32'(d0_echo), 32'd2);

    // Foreign destination: filtered here, echoed by the promiscuous instance
    clear_mon();
    build(OTHER, SRC, 40, 5);
    drive_frame(40, 1'b0);
    idle_cycles(20);
    check("foreign_no_tx", 32'(got_q.size()), 32'd0);
    check("foreign_no_valid", 32'(first_cyc), 32'hFFFF_FFFF);
    check("foreign_drop", 32'(d0_drop), 32'd1);
    check("foreign_echo", 32'(d0_echo), 32'd2);
    sel = 1'b1;
    clear_mon();
    drive_frame(40, 1'b0);
    wait_echo("promisc");
    check_echo("promisc", 40, SRC);
    check("promisc_echo", 32'(d1_echo), 32'd1);
    check("promisc_drop", 32'(d1_drop), 32'd0);
    sel = 1'b0;
    idle_cycles(2);

    // Bad-frame flag and runt frame both dropped, tx idle
    clear_mon();
    build(LMAC, SRC, 20, 9);
    drive_frame(20, 1'b1);
    build(LMAC, SRC, 13, 2);
    drive_frame(13, 1'b0);
    idle_cycles(20);
    check("bad_runt_no_tx", 32'(got_q.size()), 32'd0);
    check("bad_runt_drop", 32'(d0_drop), 32'd3);

    // Minimum 14-byte frame is still echoed
    clear_mon();
    build(LMAC, SRC, 14, 1);
    drive_frame(14, 1'b0);
    wait_echo("min14");
    check_echo("min14", 14, SRC);
    check("min14_echo", 32'(d0_echo), 32'd3);

    // Oversize frame dropped, next full-size frame unaffected
    clear_mon();
    build(LMAC, SRC, BD + 1, 4);
    drive_frame(BD + 1, 1'b0);
    idle_cycles(10);
    check("ovf_no_tx", 32'(got_q.size()), 32'd0);
    check("ovf_drop", 32'(d0_drop), 32'd4);
    build(LMAC, 48'h0A_0B_0C_0D_0E_0F, 64, 17);
    drive_frame(64, 1'b0);
    wait_echo("post_ovf");
    check_echo("post_ovf", 64, 48'h0A_0B_0C_0D_0E_0F);
    check("post_ovf_echo", 32'(d0_echo), 32'd4);

    // Echo disabled at first byte
    clear_mon();
    cfg_enable = 1'b0;
    build(LMAC, SRC, 30, 6);
    drive_frame(30, 1'b0);
    cfg_enable = 1'b1;
    idle_cycles(15);
    check("disabled_no_tx", 32'(got_q.size()), 32'd0);
    check("disabled_drop", 32'(d0_drop), 32'd5);

    // Reset in the middle of a replay
    clear_mon();
    build(LMAC, SRC, 60, 8);
    drive_frame(60, 1'b0);
    for (int w = 0; w < 100 && got_q.size() < 5; w++) idle_cycles(1);
    check("mid_send_started", 32'(got_q.size() >= 5), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_tvalid", 32'(d0_tvalid), 32'd0);
    check("rst_mid_echo", 32'(d0_echo), 32'd0);
    check("rst_mid_drop", 32'(d0_drop), 32'd0);
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(2);
    clear_mon();
    build(LMAC, 48'h11_22_33_44_55_66, 60, 21);
    drive_frame(60, 1'b0);
    wait_echo("post_rst");
    check_echo("post_rst", 60, 48'h11_22_33_44_55_66);
    check("post_rst_echo", 32'(d0_echo), 32'd1);

    idle_cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
